turn_controller: RTL and testbench
==================================

Name: turn_controller

Overview:
- Sits on the other end of the per-player move interface: consumes move/move_ready from the black and white cursor/input blocks.
- Validates each submitted move against the 9x9 board and commits legal stones to the board register.
- Drives each player's my_turn, handles passes, and declares game over after two consecutive passes.
- Capture resolution lives in a separate downstream block; this block only places stones.

Parameters:
- HANDOFF_CYCLES, 4: cycles both my_turn outputs are held low between turns, so the player blocks observe the lock.
- PASS_CODE, 8'hFF: move encoding meaning "pass".

Ports:
- clk_in  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- move_ready_b  input  1  black player's move-valid pulse
- move_b  input  8  black move: [7:4] row, [3:0] col
- move_ready_w  input  1  white player's move-valid pulse
- move_w  input  8  white move, same encoding as move_b
- my_turn_b  output  1  black may move
- my_turn_w  output  1  white may move
- board  output  2x9x9  cell encoding: 00 empty, 01 black, 10 white
- move_accepted  output  1  one-cycle pulse on each commit or accepted pass
- move_rejected  output  1  one-cycle pulse on each illegal move
- last_move  output  8  most recently accepted move (PASS_CODE for a pass)
- move_count  output  8  number of accepted moves, saturates at 255
- game_over  output  1  high after two consecutive passes

Behaviour:
- Reset (async, all registers):
  - board all 00; turn = black; my_turn_b=1, my_turn_w=0.
  - move_accepted=0, move_rejected=0; last_move=PASS_CODE; move_count=0; game_over=0; pass streak=0; state=WAIT.
- WAIT:
  - Samples only the current player's move_ready. The other player's move_ready is ignored, including when both are high in the same cycle.
  - On a sampled move_ready, latch the move into cand and go to CHECK.
- CHECK (1 cycle):
  - cand==PASS_CODE: legal pass.
  - Otherwise the move is legal iff cand[7:4]<9, cand[3:0]<9, and board[row][col]==00.
  - Any other value (e.g. row 9..15 with col 9..15, other than FF) is illegal.
  - Legal → COMMIT; illegal → REJECT.
- COMMIT (1 cycle):
  - Non-pass: write the current colour to the cell and clear the pass streak.
  - Pass: increment the pass streak.
  - In all cases: move_accepted=1, last_move=cand, move_count+=1 (saturating).
  - Pass streak reaching 2 → GAME_OVER; otherwise → HANDOFF.
- REJECT (1 cycle):
  - move_rejected=1; turn and my_turn unchanged; no board change; return to WAIT.
- HANDOFF:
  - Both my_turn outputs low for exactly HANDOFF_CYCLES cycles.
  - Then toggle turn, raise the new player's my_turn, and return to WAIT.
- GAME_OVER:
  - game_over=1, both my_turn=0; the board is frozen.
  - Terminal until reset; all move_ready inputs are ignored.
- Latency: move_ready sampled high at edge N → move_accepted or move_rejected high for the single cycle after edge N+2.
- my_turn drop timing:
  - my_turn for the mover stays high through CHECK.
  - It drops in the cycle after COMMIT, i.e. HANDOFF's first cycle.
- move_ready arriving in any state other than WAIT is dropped, with no queueing.
- The pass streak counts consecutive passes across both players; a non-pass commit clears it. A rejected move does not affect the streak.
- Reset asserted mid-HANDOFF or mid-CHECK discards all in-flight state immediately.

Test Plan:
- Reset, then black submits 8'h44 → CHECK/COMMIT, move_accepted pulse at N+2, board[4][4]=01, my_turn_b low, both my_turn low for 4 cycles, then my_turn_w=1, move_count=1.
- White submits 8'h44 (occupied) → move_rejected pulse, board unchanged, my_turn_w stays 1, move_count=1.
- White submits 8'h39 (col 9) then 8'hA0 (row 10) → two rejects; then 8'h88 → accepted, board[8][8]=10, last_move=8'h88.
- While black's turn, assert move_ready_w=1 (move 8'h00) and move_ready_b=1 (move 8'h11) in the same cycle → only 8'h11 committed, board[0][0]=00, board[1][1]=01.
- Black PASS_CODE, white PASS_CODE → game_over=1, both my_turn=0; a further move_ready_b with 8'h22 is ignored; reset restores the empty board with my_turn_b=1.
- Black pass, white stone 8'h12, black pass → game_over stays 0; also assert reset during HANDOFF → all outputs return to reset values.

Source files
------------

// File: rtl/turn_controller.sv
// Turn arbiter for a 9x9 board: validates each player's submitted move, places legal
// stones, sequences turns with a locked handoff window, and ends the game on two passes.
module turn_controller #(
    parameter int          HANDOFF_CYCLES = 4,
    parameter logic [7:0]  PASS_CODE      = 8'hFF
) (
    input  logic         clk_in,
    input  logic         reset,
    input  logic         move_ready_b,
    input  logic [7:0]   move_b,
    input  logic         move_ready_w,
    input  logic [7:0]   move_w,
    output logic         my_turn_b,
    output logic         my_turn_w,
    output logic [161:0] board,
    output logic         move_accepted,
    output logic         move_rejected,
    output logic [7:0]   last_move,
    output logic [7:0]   move_count,
    output logic         game_over
);

    localparam logic [2:0] S_WAIT      = 3'd0;
    localparam logic [2:0] S_CHECK     = 3'd1;
    localparam logic [2:0] S_COMMIT    = 3'd2;
    localparam logic [2:0] S_REJECT    = 3'd3;
    localparam logic [2:0] S_HANDOFF   = 3'd4;
    localparam logic [2:0] S_GAME_OVER = 3'd5;

    localparam logic [7:0] HANDOFF_LAST = 8'(HANDOFF_CYCLES - 1);

    // Cell (row, col) lives at flat bits [2*(9*row+col) +: 2] of the board port.
    logic [8:0][8:0][1:0] board_q, board_d;
    logic [2:0]           state_q, state_d;
    logic [7:0]           cand_q, cand_d;
    logic                 turn_q, turn_d;       // 0 = black, 1 = white
    logic [1:0]           streak_q, streak_d;
    logic [7:0]           hcnt_q, hcnt_d;
    logic                 acc_q, acc_d;
    logic                 rej_q, rej_d;
    logic [7:0]           last_q, last_d;
    logic [7:0]           count_q, count_d;

    logic       sel_ready;
    logic [7:0] sel_move;
    logic [3:0] cand_row, cand_col;
    logic       cand_is_pass, in_range, cand_legal;
    logic [1:0] cand_cell, colour;
    logic       locked;

    assign sel_ready    = turn_q ? move_ready_w : move_ready_b;
    assign sel_move     = turn_q ? move_w : move_b;
    assign cand_row     = cand_q[7:4];
    assign cand_col     = cand_q[3:0];
    assign cand_is_pass = (cand_q == PASS_CODE);
    assign in_range     = (cand_row < 4'd9) && (cand_col < 4'd9);
    assign cand_cell    = in_range ? board_q[cand_row][cand_col] : 2'b00;
    assign cand_legal   = cand_is_pass || (in_range && (cand_cell == 2'b00));
    assign colour       = turn_q ? 2'b10 : 2'b01;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        cand_d   = cand_q;
        turn_d   = turn_q;
        streak_d = streak_q;
        hcnt_d   = hcnt_q;
        board_d  = board_q;
        acc_d    = 1'b0;
        rej_d    = 1'b0;
        last_d   = last_q;
        count_d  = count_q;

        case (state_q)
            S_WAIT: begin
                if (sel_ready) begin
                    cand_d  = sel_move;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = cand_legal ? S_COMMIT : S_REJECT;
            end
            S_COMMIT: begin
                acc_d  = 1'b1;
                last_d = cand_q;
                if (count_q != 8'hFF) begin
                    count_d = count_q + 8'd1;
                end
                if (cand_is_pass) begin
                    streak_d = streak_q + 2'd1;
                end else begin
                    board_d[cand_row][cand_col] = colour;
                    streak_d = 2'd0;
                end
                if (cand_is_pass && (streak_q == 2'd1)) begin
                    state_d = S_GAME_OVER;
                end else begin
                    state_d = S_HANDOFF;
                    hcnt_d  = 8'd0;
                end
            end
            S_REJECT: begin
                rej_d   = 1'b1;
                state_d = S_WAIT;
            end
            S_HANDOFF: begin
                if (hcnt_q == HANDOFF_LAST) begin
                    turn_d  = ~turn_q;
                    state_d = S_WAIT;
                end else begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end
            S_GAME_OVER: begin
                state_d = S_GAME_OVER;
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            // NOTE: the board is plain flops with async reset, so reset always presents an empty board.
            board_q  <= '0;
            state_q  <= S_WAIT;
            cand_q   <= 8'd0;
            turn_q   <= 1'b0;
            streak_q <= 2'd0;
            hcnt_q   <= 8'd0;
            acc_q    <= 1'b0;
            rej_q    <= 1'b0;
            last_q   <= PASS_CODE;
            count_q  <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
            board_q  <= board_d;
            state_q  <= state_d;
            cand_q   <= cand_d;
            turn_q   <= turn_d;
            streak_q <= streak_d;
            hcnt_q   <= hcnt_d;
            acc_q    <= acc_d;
            rej_q    <= rej_d;
            last_q   <= last_d;
            count_q  <= count_d;
        end
    end

    assign locked        = (state_q == S_HANDOFF) || (state_q == S_GAME_OVER);
    assign my_turn_b     = !locked && !turn_q;
    assign my_turn_w     = !locked && turn_q;
    assign board         = board_q;
    assign move_accepted = acc_q;
    assign move_rejected = rej_q;
    assign last_move     = last_q;
    assign move_count    = count_q;
    assign game_over     = (state_q == S_GAME_OVER);

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller: a table of moves with hand-computed results,
// plus hand-written sequences for game-over lockout and asynchronous reset.
module tb_turn_controller;

    logic         clk_in;
    logic         reset;
    logic         move_ready_b;
    logic [7:0]   move_b;
    logic         move_ready_w;
    logic [7:0]   move_w;
    logic         my_turn_b;
    logic         my_turn_w;
    logic [161:0] board;
    logic         move_accepted;
    logic         move_rejected;
    logic [7:0]   last_move;
    logic [7:0]   move_count;
    logic         game_over;

    int checks   = 0;
    int failures = 0;

    turn_controller #(.HANDOFF_CYCLES(4), .PASS_CODE(8'hFF)) dut (
        .clk_in        (clk_in),
        .reset         (reset),
        .move_ready_b  (move_ready_b),
        .move_b        (move_b),
        .move_ready_w  (move_ready_w),
        .move_w        (move_w),
        .my_turn_b     (my_turn_b),
        .my_turn_w     (my_turn_w),
        .board         (board),
        .move_accepted (move_accepted),
        .move_rejected (move_rejected),
        .last_move     (last_move),
        .move_count    (move_count),
        .game_over     (game_over)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic       who;        // 0 = black, 1 = white
        logic [7:0] mv;
        logic       both;       // other player also raises move_ready
        logic [7:0] other_mv;
        logic       exp_acc;
        logic       exp_go;
        int         r1, c1;
        logic [1:0] cell1;
        int         r2, c2;
        logic [1:0] cell2;
        logic [7:0] count;
        logic [7:0] last;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] cell_at(input int r, input int c);
        return board[2*(9*r+c) +: 2];
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_move(input vec_t v);
        if (!v.who) begin
            move_b = v.mv;
            move_ready_b = 1'b1;
            if (v.both) begin
                move_w = v.other_mv;
                move_ready_w = 1'b1;
            end
        end else begin
            move_w = v.mv;
            move_ready_w = 1'b1;
            if (v.both) begin
                move_b = v.other_mv;
                move_ready_b = 1'b1;
            end
        end
        step();
        move_ready_b = 1'b0;
        move_ready_w = 1'b0;
        check("no_pulse_n1", {move_accepted, move_rejected}, 2'b00);
        step();
        check("no_pulse_n2", {move_accepted, move_rejected}, 2'b00);
        step();
        check("accepted_n2", move_accepted, v.exp_acc);
        check("rejected_n2", move_rejected, !v.exp_acc);
        if (v.exp_acc) begin
            check("turns_locked", {my_turn_b, my_turn_w}, 2'b00);
            check("game_over", game_over, v.exp_go);
            if (!v.exp_go) begin
                for (int i = 0; i < 3; i++) begin
                    step();
                    check("handoff_low", {my_turn_b, my_turn_w, move_accepted}, 3'b000);
                end
                step();
                check("turn_b_next", my_turn_b, v.who);
                check("turn_w_next", my_turn_w, !v.who);
            end
        end else begin
            check("turn_b_kept", my_turn_b, !v.who);
            check("turn_w_kept", my_turn_w, v.who);
            step();
            check("reject_pulse_end", move_rejected, 1'b0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_board"}, (board == '0), 1'b1);
        check({tag, "_turns"}, {my_turn_b, my_turn_w}, 2'b10);
        check({tag, "_pulses"}, {move_accepted, move_rejected}, 2'b00);
        check({tag, "_last"}, last_move, 8'hFF);
        check({tag, "_count"}, move_count, 8'd0);
        check({tag, "_game_over"}, game_over, 1'b0);
    endtask

    initial begin
        //        who   mv     both  oth    acc   go    r1 c1 cell1  r2 c2 cell2  count  last
        vecs[0]  = '{1'b0, 8'h44, 1'b0, 8'h00, 1'b1, 1'b0, 4, 4, 2'b01, 0, 0, 2'b00, 8'd1, 8'h44};
        vecs[1]  = '{1'b1, 8'h44, 1'b0, 8'h00, 1'b0, 1'b0, 4, 4, 2'b01, 8, 8, 2'b00, 8'd1, 8'h44};
        vecs[2]  = '{1'b1, 8'h39, 1'b0, 8'h00, 1'b0, 1'b0, 4, 4, 2'b01, 3, 8, 2'b00, 8'd1, 8'h44};
        vecs[3]  = '{1'b1, 8'hA0, 1'b0, 8'h00, 1'b0, 1'b0, 4, 4, 2'b01, 8, 0, 2'b00, 8'd1, 8'h44};
        vecs[4]  = '{1'b1, 8'h88, 1'b0, 8'h00, 1'b1, 1'b0, 8, 8, 2'b10, 4, 4, 2'b01, 8'd2, 8'h88};
        vecs[5]  = '{1'b0, 8'h11, 1'b1, 8'h00, 1'b1, 1'b0, 1, 1, 2'b01, 0, 0, 2'b00, 8'd3, 8'h11};
        vecs[6]  = '{1'b1, 8'h23, 1'b0, 8'h00, 1'b1, 1'b0, 2, 3, 2'b10, 2, 2, 2'b00, 8'd4, 8'h23};
        vecs[7]  = '{1'b0, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0, 2, 3, 2'b10, 4, 4, 2'b01, 8'd5, 8'hFF};
        vecs[8]  = '{1'b1, 8'h12, 1'b0, 8'h00, 1'b1, 1'b0, 1, 2, 2'b10, 1, 1, 2'b01, 8'd6, 8'h12};
        vecs[9]  = '{1'b0, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0, 1, 2, 2'b10, 8, 8, 2'b10, 8'd7, 8'hFF};
        vecs[10] = '{1'b1, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b1, 4, 4, 2'b01, 2, 2, 2'b00, 8'd8, 8'hFF};

        reset = 1'b1;
        move_ready_b = 1'b0;
        move_ready_w = 1'b0;
        move_b = 8'h00;
        move_w = 8'h00;
        step();
        step();
        reset = 1'b0;
        check_reset_state("reset");

        for (int i = 0; i < 11; i++) begin
            do_move(vecs[i]);
            check($sformatf("v%0d_cell1", i), cell_at(vecs[i].r1, vecs[i].c1), vecs[i].cell1);
            check($sformatf("v%0d_cell2", i), cell_at(vecs[i].r2, vecs[i].c2), vecs[i].cell2);
            check($sformatf("v%0d_count", i), move_count, vecs[i].count);
            check($sformatf("v%0d_last", i), last_move, vecs[i].last);
            check($sformatf("v%0d_game_over", i), game_over, vecs[i].exp_go);
        end

        // Game over is terminal: a further black move is ignored.
        move_b = 8'h22;
        move_ready_b = 1'b1;
        step();
        move_ready_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("go_no_pulse", {move_accepted, move_rejected}, 2'b00);
        end
        check("go_cell22", cell_at(2, 2), 2'b00);
        check("go_count", move_count, 8'd8);
        check("go_held", game_over, 1'b1);
        check("go_turns", {my_turn_b, my_turn_w}, 2'b00);

        // Asynchronous reset out of game over.
        reset = 1'b1;
        #2;
        check_reset_state("go_reset");
        step();
        reset = 1'b0;
        check_reset_state("go_release");

        // Reset asserted mid-handoff discards the move in flight.
        move_b = 8'h55;
        move_ready_b = 1'b1;
        step();
        move_ready_b = 1'b0;
        step();
        step();
        check("ho_accepted", move_accepted, 1'b1);
        check("ho_cell55", cell_at(5, 5), 2'b01);
        step();
        check("ho_locked", {my_turn_b, my_turn_w}, 2'b00);
        reset = 1'b1;
        #2;
        check_reset_state("ho_reset");
        step();
        reset = 1'b0;
        check_reset_state("ho_release");

        do_move('{1'b0, 8'h66, 1'b0, 8'h00, 1'b1, 1'b0, 6, 6, 2'b01, 5, 5, 2'b00, 8'd1, 8'h66});
        check("post_cell66", cell_at(6, 6), 2'b01);
        check("post_cell55", cell_at(5, 5), 2'b00);
        check("post_count", move_count, 8'd1);
        check("post_last", last_move, 8'h66);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
